// File: rtl/fib_rr_sched.sv
// Round-robin scheduler sharing one Fibonacci engine between NUM_REQ requesters.
// One transaction is in flight at a time: IDLE arbitrates, ISSUE pulses go,
// WAIT watches for done under a watchdog, RESP returns a one-cycle response.
module fib_rr_sched #(
    parameter int NUM_REQ        = 4,
    parameter int INPUT_WIDTH    = 6,
    parameter int OUTPUT_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_n,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [OUTPUT_WIDTH-1:0]        rsp_result,
    output logic                           rsp_overflow,
    output logic                           rsp_timeout,
    output logic                           busy,
    output logic                           go,
    output logic [INPUT_WIDTH-1:0]         n,
    input  logic                           done,
    input  logic [OUTPUT_WIDTH-1:0]        result,
    input  logic                           overflow
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         winner_q, winner_d;
    logic [INPUT_WIDTH-1:0]  n_q, n_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OUTPUT_WIDTH-1:0] cap_result_q, cap_result_d;
    logic                    cap_overflow_q, cap_overflow_d;
    logic                    cap_timeout_q, cap_timeout_d;

    logic                    grant_found;
    logic [ID_W-1:0]         grant_id;
    int unsigned             scan_idx;
    logic [ID_W-1:0]         scan_id;

    logic [INPUT_WIDTH-1:0]  req_n_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_n_arr[gi] = req_n[gi*INPUT_WIDTH +: INPUT_WIDTH];
    end

    // Round-robin pick: first pending requester at or above ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        scan_id     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = 32'(ptr_q) + 32'(k);
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            scan_id = ID_W'(scan_idx);
            if (!grant_found && req_valid[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    // Next-state logic for the FSM, pointer, operand latch, watchdog and capture.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        winner_d       = winner_q;
        n_d            = n_q;
        cnt_d          = cnt_q;
        cap_result_d   = cap_result_q;
        cap_overflow_d = cap_overflow_q;
        cap_timeout_d  = cap_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    winner_d = grant_id;
                    n_d      = req_n_arr[grant_id];
                    ptr_d    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    cap_result_d   = result;
                    cap_overflow_d = overflow;
                    cap_timeout_d  = 1'b0;
                    state_d        = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // Watchdog expired: report an aborted, zero-valued response.
                    cap_result_d   = '0;
                    cap_overflow_d = 1'b0;
                    cap_timeout_d  = 1'b1;
                    state_d        = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight transaction without a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            winner_q       <= '0;
            n_q            <= '0;
            cnt_q          <= '0;
            cap_result_q   <= '0;
            cap_overflow_q <= 1'b0;
            cap_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            winner_q       <= winner_d;
            n_q            <= n_d;
            cnt_q          <= cnt_d;
            cap_result_q   <= cap_result_d;
            cap_overflow_q <= cap_overflow_d;
            cap_timeout_q  <= cap_timeout_d;
        end
    end

    // Outputs decode from registered state so reset clears them immediately.
    always_comb begin
        rsp_valid    = '0;
        rsp_result   = '0;
        rsp_overflow = 1'b0;
        rsp_timeout  = 1'b0;
        busy         = (state_q != ST_IDLE);
        go           = (state_q == ST_ISSUE);
        n            = n_q;
        if (state_q == ST_RESP) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid[i] = (winner_q == ID_W'(i));
            end
            rsp_result   = cap_result_q;
            rsp_overflow = cap_overflow_q;
            rsp_timeout  = cap_timeout_q;
        end
    end

endmodule

// File: tb/tb_fib_rr_sched.sv
// Self-checking bench for fib_rr_sched with a behavioural Fibonacci engine model.
module tb_fib_rr_sched;

    localparam int NR = 4;
    localparam int IW = 6;
    localparam int OW = 32;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req_valid = '0;
    logic [NR*IW-1:0] req_n = '0;
    logic [NR-1:0]  rsp_valid;
    logic [OW-1:0]  rsp_result;
    logic           rsp_overflow;
    logic           rsp_timeout;
    logic           busy;
    logic           go;
    logic [IW-1:0]  n;
    logic           done = 1'b0;
    logic [OW-1:0]  result = '0;
    logic           overflow = 1'b0;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Engine model controls
    int            eng_lat  = 1;
    bit            eng_hang = 1'b0;
    int            eng_cnt  = -1;
    logic [IW-1:0] eng_n    = '0;

    fib_rr_sched #(
        .NUM_REQ(NR), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .rsp_timeout(rsp_timeout), .busy(busy), .go(go), .n(n),
        .done(done), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fib64(input int k);
        logic [63:0] a, b, t;
        a = 64'd0;
        b = 64'd1;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic set_n(input int i, input int v);
        logic [IW-1:0] tmp;
        tmp = IW'(v);
        req_n[i*IW +: IW] = tmp;
    endtask

    // Advance one cycle, then let the engine model react (done is a 1-cycle pulse).
    task automatic tick();
        logic [63:0] f;
        @(posedge clk);
        #1;
        cyc++;
        done     = 1'b0;
        result   = $urandom;
        overflow = 1'($urandom_range(0, 1));
        if (rst) begin
            eng_cnt = -1;
        end else begin
            if (eng_cnt == 0) begin
                f        = fib64(int'(eng_n));
                done     = 1'b1;
                result   = f[31:0];
                overflow = |f[63:32];
                eng_cnt  = -1;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
            end
            if (go) begin
                eng_n   = n;
                eng_cnt = eng_hang ? -1 : eng_lat;
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_n     = '0;
        eng_hang  = 1'b0;
        eng_lat   = 1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        tick();
        tick();
        n_total++;
        if (rsp_valid !== '0) $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid);
        else n_pass++;
        n_total++;
        if (rsp_result !== '0) $display("FAIL reset_rsp_result got=%0h want=0", rsp_result);
        else n_pass++;
        n_total++;
        if ({rsp_overflow, rsp_timeout} !== 2'b00)
            $display("FAIL reset_rsp_flags got=%b want=00", {rsp_overflow, rsp_timeout});
        else n_pass++;
        n_total++;
        if ({busy, go} !== 2'b00) $display("FAIL reset_busy_go got=%b want=00", {busy, go});
        else n_pass++;
        n_total++;
        if (n !== '0) $display("FAIL reset_n got=%0d want=0", n);
        else n_pass++;
        req_valid = '0;
        rst       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_total++;
            if ({busy, go, rsp_valid} !== '0)
                $display("FAIL idle_quiet cyc=%0d got busy=%b go=%b rsp_valid=%b want 0",
                         i, busy, go, rsp_valid);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        int ngo, go_n, c0, rcyc;
        logic [NR-1:0] rv;
        logic [OW-1:0] rr;
        logic ro, rt;
        bit got;
        do_reset();
        eng_lat = 5;
        set_n(2, 10);
        req_valid = 4'b0100;
        c0 = cyc;
        ngo = 0; go_n = -1; got = 0; rcyc = 0; rv = '0; rr = '0; ro = 0; rt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (got && cyc == rcyc + 1) req_valid = '0;
            if (go) begin
                ngo++;
                go_n = int'(n);
            end
            if (rsp_valid != '0 && !got) begin
                got = 1; rcyc = cyc; rv = rsp_valid; rr = rsp_result;
                ro = rsp_overflow; rt = rsp_timeout;
            end
        end
        n_total++;
        if (!got) $display("FAIL single_got got=0 want=1");
        else n_pass++;
        n_total++;
        if (ngo != 1) $display("FAIL single_go_count got=%0d want=1", ngo);
        else n_pass++;
        n_total++;
        if (go_n != 10) $display("FAIL single_go_n got=%0d want=10", go_n);
        else n_pass++;
        n_total++;
        if (rcyc - c0 != 8) $display("FAIL single_latency got=%0d want=8", rcyc - c0);
        else n_pass++;
        n_total++;
        if (rv !== 4'b0100) $display("FAIL single_rsp_valid got=%b want=0100", rv);
        else n_pass++;
        n_total++;
        if (rr !== 32'd55) $display("FAIL single_result got=%0d want=55", rr);
        else n_pass++;
        n_total++;
        if ({ro, rt} !== 2'b00) $display("FAIL single_flags got=%b want=00", {ro, rt});
        else n_pass++;
    endtask

    task automatic test_all_four();
        logic [NR-1:0] vecs [8];
        logic [OW-1:0] ress [8];
        logic [NR-1:0] ev;
        logic [63:0] f;
        int cnt;
        do_reset();
        eng_lat = 2;
        for (int i = 0; i < NR; i++) set_n(i, i + 1);
        req_valid = '1;
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 8; i++) begin
            tick();
            if (rsp_valid != '0) begin
                vecs[cnt] = rsp_valid;
                ress[cnt] = rsp_result;
                cnt++;
            end
        end
        tick();
        req_valid = '0;
        n_total++;
        if (cnt != 8) $display("FAIL rr_count got=%0d want=8", cnt);
        else n_pass++;
        for (int k = 0; k < cnt; k++) begin
            ev = '0;
            ev[k % NR] = 1'b1;
            f = fib64((k % NR) + 1);
            n_total++;
            if (vecs[k] !== ev) $display("FAIL rr_order k=%0d got=%b want=%b", k, vecs[k], ev);
            else n_pass++;
            n_total++;
            if (ress[k] !== f[31:0])
                $display("FAIL rr_result k=%0d got=%0d want=%0d", k, ress[k], f[31:0]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [NR-1:0] rv;
        logic [OW-1:0] rr;
        logic ro, rt;
        logic [63:0] f;
        int rcyc;
        bit got;
        do_reset();
        eng_lat = 3;
        set_n(1, 48);
        req_valid = 4'b0010;
        got = 0; rcyc = 0; rv = '0; rr = '0; ro = 0; rt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (got && cyc == rcyc + 1) req_valid = '0;
            if (rsp_valid != '0 && !got) begin
                got = 1; rcyc = cyc; rv = rsp_valid; rr = rsp_result;
                ro = rsp_overflow; rt = rsp_timeout;
            end
        end
        f = fib64(48);
        n_total++;
        if (rv !== 4'b0010) $display("FAIL ovf_rsp_valid got=%b want=0010", rv);
        else n_pass++;
        n_total++;
        if (ro !== 1'b1) $display("FAIL ovf_flag got=%b want=1", ro);
        else n_pass++;
        n_total++;
        if (rr !== f[31:0]) $display("FAIL ovf_result got=%0h want=%0h", rr, f[31:0]);
        else n_pass++;
        n_total++;
        if (rt !== 1'b0) $display("FAIL ovf_timeout got=%b want=0", rt);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [NR-1:0] rv;
        logic [OW-1:0] rr;
        logic ro, rt;
        int g, rcyc;
        bit got, idle_seen;
        do_reset();
        eng_hang = 1'b1;
        set_n(0, 7);
        req_valid = 4'b0001;
        got = 0; g = -1000; rcyc = 0; rv = '0; rr = '1; ro = 1; rt = 0; idle_seen = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (go) g = cyc;
            if (rsp_valid != '0) begin
                got = 1; rcyc = cyc; rv = rsp_valid; rr = rsp_result;
                ro = rsp_overflow; rt = rsp_timeout;
            end
        end
        tick();
        req_valid = '0;
        idle_seen = !busy;
        n_total++;
        if (rcyc - g != TO + 1) $display("FAIL to_latency got=%0d want=%0d", rcyc - g, TO + 1);
        else n_pass++;
        n_total++;
        if ({rv, rt} !== {4'b0001, 1'b1})
            $display("FAIL to_flag got rsp_valid=%b timeout=%b want 0001/1", rv, rt);
        else n_pass++;
        n_total++;
        if ({rr, ro} !== '0) $display("FAIL to_zero got result=%0h ovf=%b want 0/0", rr, ro);
        else n_pass++;
        n_total++;
        if (!idle_seen) $display("FAIL to_idle got busy=1 want busy=0");
        else n_pass++;
        // Next request is served normally.
        eng_hang = 1'b0;
        eng_lat  = 4;
        set_n(3, 6);
        req_valid = 4'b1000;
        got = 0; rv = '0; rr = '0; rt = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (got && cyc == rcyc + 1) req_valid = '0;
            if (rsp_valid != '0 && !got) begin
                got = 1; rcyc = cyc; rv = rsp_valid; rr = rsp_result; rt = rsp_timeout;
            end
        end
        n_total++;
        if ({rv, rr, rt} !== {4'b1000, 32'd8, 1'b0})
            $display("FAIL to_recover got rsp_valid=%b result=%0d timeout=%b want 1000/8/0",
                     rv, rr, rt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int first_n, spurious;
        logic [NR-1:0] rv;
        logic [OW-1:0] rr;
        bit seen_go, got;
        do_reset();
        eng_lat = 10;
        set_n(1, 5);
        set_n(3, 9);
        req_valid = 4'b1010;
        seen_go = 0;
        for (int i = 0; i < 10 && !seen_go; i++) begin
            tick();
            if (go) seen_go = 1;
        end
        repeat (3) tick();
        n_total++;
        if (busy !== 1'b1) $display("FAIL mid_busy_wait got=%b want=1", busy);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({rsp_valid, rsp_result, rsp_overflow, rsp_timeout, busy, go, n} !== '0)
            $display("FAIL mid_async_clear got rsp_valid=%b busy=%b go=%b n=%0d want all 0",
                     rsp_valid, busy, go, n);
        else n_pass++;
        tick();
        n_total++;
        if ({rsp_valid, busy} !== '0)
            $display("FAIL mid_held got rsp_valid=%b busy=%b want 0", rsp_valid, busy);
        else n_pass++;
        rst = 1'b0;
        first_n = -1; spurious = 0; got = 0; rv = '0; rr = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (go && first_n < 0) first_n = int'(n);
            if (rsp_valid != '0) begin
                if (first_n < 0) spurious++;
                else begin
                    got = 1; rv = rsp_valid; rr = rsp_result;
                end
            end
        end
        req_valid = '0;
        n_total++;
        if (spurious != 0) $display("FAIL mid_spurious got=%0d want=0", spurious);
        else n_pass++;
        n_total++;
        if (first_n != 5) $display("FAIL mid_ptr_restart got n=%0d want=5", first_n);
        else n_pass++;
        n_total++;
        if ({rv, rr} !== {4'b0010, 32'd5})
            $display("FAIL mid_rsp got rsp_valid=%b result=%0d want 0010/5", rv, rr);
        else n_pass++;
    endtask

    // Randomized traffic against a transaction-level round-robin reference model.
    task automatic test_random();
        int mptr, w, go_cyc, rsp_cyc, lat;
        bit txn, rsp_now, hang, found;
        logic [IW-1:0] exp_n;
        logic [OW-1:0] exp_res;
        logic exp_ovf, exp_to;
        logic [NR-1:0] hold, drop, e_rv;
        logic [63:0] f;
        do_reset();
        mptr = 0; w = 0; txn = 0; go_cyc = 0; rsp_cyc = 0;
        exp_n = '0; exp_res = '0; exp_ovf = 0; exp_to = 0; drop = '0;
        for (int it = 0; it < 1500; it++) begin
            tick();
            rsp_now = txn && (cyc == rsp_cyc);
            n_total++;
            if (go !== (txn && cyc == go_cyc))
                $display("FAIL rnd_go cyc=%0d got=%b want=%b", cyc, go, txn && cyc == go_cyc);
            else n_pass++;
            if (txn && cyc == go_cyc) begin
                n_total++;
                if (n !== exp_n) $display("FAIL rnd_n cyc=%0d got=%0d want=%0d", cyc, n, exp_n);
                else n_pass++;
            end
            n_total++;
            if (busy !== (txn && cyc >= go_cyc))
                $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, busy, txn && cyc >= go_cyc);
            else n_pass++;
            e_rv = '0;
            if (rsp_now) e_rv[w] = 1'b1;
            n_total++;
            if (rsp_valid !== e_rv)
                $display("FAIL rnd_rsp_valid cyc=%0d got=%b want=%b", cyc, rsp_valid, e_rv);
            else n_pass++;
            n_total++;
            if ({rsp_result, rsp_overflow, rsp_timeout} !==
                (rsp_now ? {exp_res, exp_ovf, exp_to} : '0))
                $display("FAIL rnd_payload cyc=%0d got=%0h/%b/%b want=%0h/%b/%b rsp=%b", cyc,
                         rsp_result, rsp_overflow, rsp_timeout, exp_res, exp_ovf, exp_to,
                         rsp_now);
            else n_pass++;
            hold = '0;
            if (txn) hold[w] = 1'b1;
            if (rsp_now) txn = 0;
            for (int i = 0; i < NR; i++) begin
                if (drop[i]) req_valid[i] = 1'b0;
                else if (!hold[i]) begin
                    if (!req_valid[i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            req_valid[i] = 1'b1;
                            set_n(i, $urandom_range(0, 63));
                        end
                    end else if ($urandom_range(0, 23) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            drop = rsp_now ? hold : '0;
            if (!txn && !rsp_now && req_valid != '0) begin
                found = 0;
                for (int k = 0; k < NR; k++) begin
                    if (!found && req_valid[(mptr + k) % NR]) begin
                        found = 1;
                        w = (mptr + k) % NR;
                    end
                end
                mptr    = (w + 1) % NR;
                exp_n   = req_n[w*IW +: IW];
                hang    = ($urandom_range(0, 7) == 0);
                lat     = $urandom_range(0, 12);
                eng_hang = hang;
                eng_lat  = lat;
                go_cyc  = cyc + 1;
                if (hang) begin
                    rsp_cyc = go_cyc + TO + 1;
                    exp_res = '0; exp_ovf = 0; exp_to = 1;
                end else begin
                    rsp_cyc = go_cyc + lat + 2;
                    f = fib64(int'(exp_n));
                    exp_res = f[31:0]; exp_ovf = |f[63:32]; exp_to = 0;
                end
                txn = 1;
            end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout got=stuck want=finish");
        $fatal(1, "bench time limit");
    end

endmodule
